// File: rtl/aurora_stream_mux_if.sv
// -----------------------------------------------------------------------------
// aurora_stream_mux_if
//   AXI-stream signal bundle between aurora_stream_mux and the aurora_8b10b
//   core.
//   TX (mux -> core): tx_data, tx_valid, with tx_ready coming back.
//   RX (core -> mux): rx_data, rx_valid. There is no ready signal because the
//   RX side of the core cannot be backpressured.
//   modport master : the mux side (drives TX, consumes RX)
//   modport slave  : the core side (consumes TX, drives RX)
// -----------------------------------------------------------------------------
interface aurora_stream_mux_if #(
    parameter int DW = 32
);
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid
    );
endinterface

// File: rtl/aurora_stream_mux.sv
// -----------------------------------------------------------------------------
// aurora_stream_mux
//   Multiplexes NCH first-word-fall-through TX FIFOs onto one Aurora AXI-stream
//   TX interface as length-framed packets, using round-robin arbitration. It
//   also demultiplexes received packets into NCH RX FIFOs by channel ID.
//   Header word: [31:24]=8'hA5, [23:16]=channel ID, [15:0]=payload length.
//   The whole block runs in the user_clk domain.
//
// Ports
//   user_clk, rst         clock; asynchronous active-high reset
//   channel_up            Aurora CHANNEL_UP; losing it aborts TX and resyncs RX
//   tx_fifo_dat_i/cnt_i/empty_i, tx_fifo_rd_o
//                         per-channel TX FIFO head, occupancy, empty, pop
//   rx_fifo_dat_o, rx_fifo_wr_o, rx_fifo_full_i
//                         shared RX write data, one-hot write strobe, full
//   axis                  AXI-stream TX/RX towards the Aurora core (master)
//   rx_drop_cnt, hdr_err_cnt, tx_abort_cnt
//                         saturating 16-bit error counters
// -----------------------------------------------------------------------------
module aurora_stream_mux #(
    parameter int DW        = 32,
    parameter int NCH       = 2,
    parameter int MAX_BURST = 64,
    parameter int CNTW      = 16
) (
    input  logic                 user_clk,
    input  logic                 rst,
    input  logic                 channel_up,
    input  logic [NCH*DW-1:0]    tx_fifo_dat_i,
    input  logic [NCH*CNTW-1:0]  tx_fifo_cnt_i,
    input  logic [NCH-1:0]       tx_fifo_empty_i,
    output logic [NCH-1:0]       tx_fifo_rd_o,
    output logic [DW-1:0]        rx_fifo_dat_o,
    output logic [NCH-1:0]       rx_fifo_wr_o,
    input  logic [NCH-1:0]       rx_fifo_full_i,
    aurora_stream_mux_if.master  axis,
    output logic [15:0]          rx_drop_cnt,
    output logic [15:0]          hdr_err_cnt,
    output logic [15:0]          tx_abort_cnt
);
    localparam int         CHW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [7:0] MAGIC = 8'hA5;

    typedef enum logic [1:0] {T_IDLE, T_HDR, T_DATA} tx_state_t;
    typedef enum logic       {R_HDR, R_DATA}         rx_state_t;

    // ---------------------------------------------------------------- TX side
    tx_state_t      tx_state, tx_state_nxt;
    logic [CHW-1:0] ptr, ptr_nxt, ch, ch_nxt;
    logic [15:0]    len, len_nxt, remaining, remaining_nxt;
    logic           abort;

    logic           found;
    logic [CHW-1:0] win;
    logic [15:0]    win_len;

    // Round-robin scan. Walking from the farthest candidate (ptr+NCH) down to
    // the nearest (ptr+1) lets the last hit win, so no early loop exit is needed.
    always_comb begin
        int          idx;
        logic [31:0] cnt;
        // NOTE: every always_comb output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        found   = 1'b0;
        win     = '0;
        win_len = '0;
        idx     = 0;
        cnt     = '0;
        for (int i = NCH; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NCH;
            cnt = 32'(tx_fifo_cnt_i[idx*CNTW +: CNTW]);
            if (cnt != 32'd0) begin
                found   = 1'b1;
                win     = CHW'(idx);
                win_len = (cnt > 32'(MAX_BURST)) ? 16'(MAX_BURST) : 16'(cnt);
            end
        end
    end

    logic [DW-1:0] hdr_word;
    logic [DW-1:0] head_word;
    assign hdr_word  = DW'({MAGIC, 8'(ch), len});
    assign head_word = tx_fifo_dat_i[ch*DW +: DW];

    always_comb begin
        tx_state_nxt  = tx_state;
        ptr_nxt       = ptr;
        ch_nxt        = ch;
        len_nxt       = len;
        remaining_nxt = remaining;
        abort         = 1'b0;
        axis.tx_valid = 1'b0;
        axis.tx_data  = '0;
        tx_fifo_rd_o  = '0;
        case (tx_state)
            T_IDLE: begin
                if (channel_up && found) begin
                    ch_nxt       = win;
                    len_nxt      = win_len;
                    tx_state_nxt = T_HDR;
                end
            end
            T_HDR: begin
                if (!channel_up) begin
                    tx_state_nxt = T_IDLE;
                end else begin
                    axis.tx_valid = 1'b1;
                    axis.tx_data  = hdr_word;
                    if (axis.tx_ready) begin
                        remaining_nxt = len;
                        tx_state_nxt  = T_DATA;
                    end
                end
            end
            T_DATA: begin
                if (!channel_up) begin
                    // Unsent words stay in the FIFO; the next packet re-arbitrates.
                    abort        = 1'b1;
                    tx_state_nxt = T_IDLE;
                end else begin
                    axis.tx_valid = ~tx_fifo_empty_i[ch];
                    axis.tx_data  = head_word;
                    if (!tx_fifo_empty_i[ch] && axis.tx_ready) begin
                        tx_fifo_rd_o[ch] = 1'b1;
                        remaining_nxt    = remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            ptr_nxt      = ch;
                            tx_state_nxt = T_IDLE;
                        end
                    end
                end
            end
            default: tx_state_nxt = T_IDLE;
        endcase
    end

    // The pointer resets to the last channel so channel 0 is scanned first.
    always_ff @(posedge user_clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of process order.
            tx_state     <= T_IDLE;
            ptr          <= CHW'(NCH - 1);
            ch           <= '0;
            len          <= '0;
            remaining    <= '0;
            tx_abort_cnt <= '0;
        end else begin
            tx_state  <= tx_state_nxt;
            ptr       <= ptr_nxt;
            ch        <= ch_nxt;
            len       <= len_nxt;
            remaining <= remaining_nxt;
            if (abort && tx_abort_cnt != 16'hFFFF)
                tx_abort_cnt <= tx_abort_cnt + 16'd1;
        end
    end

    // ---------------------------------------------------------------- RX side
    rx_state_t      rx_state, rx_state_nxt;
    logic [CHW-1:0] rch;
    logic [15:0]    rrem;
    logic           hdr_ok, hdr_bad, pay;

    logic [7:0]  rx_magic, rx_id;
    logic [15:0] rx_len;
    assign rx_magic = axis.rx_data[31:24];
    assign rx_id    = axis.rx_data[23:16];
    assign rx_len   = axis.rx_data[15:0];

    always_comb begin
        rx_state_nxt = rx_state;
        hdr_ok       = 1'b0;
        hdr_bad      = 1'b0;
        pay          = 1'b0;
        if (!channel_up) begin
            rx_state_nxt = R_HDR;
        end else if (axis.rx_valid) begin
            case (rx_state)
                R_HDR: begin
                    if (rx_magic == MAGIC && rx_id < 8'(NCH) &&
                        rx_len != 16'd0 && rx_len <= 16'(MAX_BURST)) begin
                        hdr_ok       = 1'b1;
                        rx_state_nxt = R_DATA;
                    end else begin
                        hdr_bad = 1'b1;
                    end
                end
                R_DATA: begin
                    pay = 1'b1;
                    if (rrem == 16'd1)
                        rx_state_nxt = R_HDR;
                end
                default: rx_state_nxt = R_HDR;
            endcase
        end
    end

    // The full flag is sampled alongside rx_valid while the write lands one
    // cycle later, so the RX FIFO needs one word of slack.
    always_ff @(posedge user_clk or posedge rst) begin
        if (rst) begin
            rx_state      <= R_HDR;
            rch           <= '0;
            rrem          <= '0;
            rx_fifo_wr_o  <= '0;
            rx_fifo_dat_o <= '0;
            rx_drop_cnt   <= '0;
            hdr_err_cnt   <= '0;
        end else begin
            rx_state     <= rx_state_nxt;
            rx_fifo_wr_o <= '0;
            if (hdr_ok) begin
                rch  <= CHW'(rx_id);
                rrem <= rx_len;
            end
            if (pay) begin
                rrem <= rrem - 16'd1;
                if (!rx_fifo_full_i[rch]) begin
                    rx_fifo_wr_o  <= NCH'(1) << rch;
                    rx_fifo_dat_o <= axis.rx_data;
                end else if (rx_drop_cnt != 16'hFFFF) begin
                    rx_drop_cnt <= rx_drop_cnt + 16'd1;
                end
            end
            if (hdr_bad && hdr_err_cnt != 16'hFFFF)
                hdr_err_cnt <= hdr_err_cnt + 16'd1;
        end
    end
endmodule

// File: doc/aurora_stream_mux.md
# aurora_stream_mux

Parametrised successor to the single-channel Aurora FIFO controller. It multiplexes NCH local transmit FIFOs onto one Aurora AXI-stream TX interface as length-framed packets, using round-robin arbitration. On the receive side it demultiplexes incoming packets into NCH receive FIFOs by channel ID. It sits between the user FIFOs and the aurora_8b10b core, entirely in the user_clk domain.

## Interface
Parameters:
- DW, 32: stream and FIFO data width; must be ≥ 32.
- NCH, 2: number of virtual channels; legal range 1..8.
- MAX_BURST, 64: maximum payload words per packet; legal range 1..65535.
- CNTW, 16: width of each TX FIFO occupancy count.

Ports:
- user_clk  in  1  Aurora user clock; the only clock.
- rst  in  1  reset; asynchronous, active-high.
- channel_up  in  1  Aurora CHANNEL_UP.
- tx_fifo_dat_i  in  NCH*DW  per-channel FWFT FIFO head word; channel k occupies [k*DW +: DW].
- tx_fifo_cnt_i  in  NCH*CNTW  per-channel occupancy, in words.
- tx_fifo_empty_i  in  NCH  per-channel empty flag.
- tx_fifo_rd_o  out  NCH  per-channel pop strobe.
- rx_fifo_dat_o  out  DW  write data, shared by all RX FIFOs.
- rx_fifo_wr_o  out  NCH  per-channel write strobe; one-hot or zero.
- rx_fifo_full_i  in  NCH  per-channel full flag.
- tx_data  out  DW  to S_AXI_TX_TDATA.
- tx_valid  out  1  to S_AXI_TX_TVALID.
- tx_ready  in  1  from S_AXI_TX_TREADY.
- rx_data  in  DW  from M_AXI_RX_TDATA.
- rx_valid  in  1  from M_AXI_RX_TVALID. There is no backpressure on this interface.
- rx_drop_cnt  out  16  saturating count of payload words dropped because the destination FIFO was full.
- hdr_err_cnt  out  16  saturating count of rejected header words.
- tx_abort_cnt  out  16  saturating count of TX packets truncated by channel loss.

## Operation
- Header word format: [31:24]=8'hA5, [23:16]=channel ID, [15:0]=payload length in words. Bits [DW-1:32] are zero.
- TX FSM has three states: T_IDLE, T_HDR, T_DATA. Reset state is T_IDLE, and the round-robin pointer resets to NCH-1, so channel 0 wins first.
- T_IDLE, when channel_up=1: scan channels starting at pointer+1 (mod NCH) for the first channel with cnt≥1. Latch that channel as ch, latch len=min(cnt, MAX_BURST), go to T_HDR. If no channel qualifies, stay in T_IDLE.
- T_HDR: tx_valid=1 and tx_data=header. On tx_ready → T_DATA with remaining=len.
- T_DATA: tx_data=tx_fifo_dat_i[ch] and tx_valid=~tx_fifo_empty_i[ch]. tx_fifo_rd_o[ch]=tx_valid&tx_ready. Each accepted word decrements remaining. When the word with remaining=1 is accepted → T_IDLE and pointer←ch.
- channel_up=0 in T_HDR or T_DATA: go to T_IDLE on the next edge. tx_valid deasserts in that cycle. If in T_DATA, tx_abort_cnt increments. Unsent words stay in the FIFO.
- RX FSM has two states: R_HDR (reset state) and R_DATA.
- R_HDR: when rx_valid=1, the word is a valid header if magic=A5, ID<NCH and 1≤len≤MAX_BURST. A valid header latches rch and rlen, then → R_DATA. Otherwise hdr_err_cnt increments and the FSM stays in R_HDR.
- R_DATA: each rx_valid word is a payload word.
  - If rx_fifo_full_i[rch]=0, the word is written to FIFO rch.
  - If rx_fifo_full_i[rch]=1, the word is discarded and rx_drop_cnt increments.
  - The last word (count reaches rlen) → R_HDR.
- channel_up=0 in any state: the RX FSM returns to R_HDR on the next edge. Any in-flight registered write still completes.
- All three counters saturate at 16'hFFFF and clear only on rst.
- rst mid-packet: both FSMs go to idle immediately. All strobes go to 0. No FIFO is popped or written after rst asserts.

## Timing
- Reset values: tx_valid=0, tx_data=0, tx_fifo_rd_o=0, rx_fifo_wr_o=0, rx_fifo_dat_o=0, all counters 0.
- TX outputs are combinational from registered state plus FIFO head. tx_fifo_rd_o is also combinational with tx_ready.
- Arbitration takes 1 cycle. The header appears the cycle after T_IDLE sees a non-empty channel.
- Minimum packet cost is len+2 cycles: one idle cycle, one header cycle, then len data cycles.
- RX write is registered. An rx_valid word at edge n gives rx_fifo_wr_o and rx_fifo_dat_o at edge n+1, asserted for exactly 1 cycle.
- The full check uses rx_fifo_full_i sampled in the same cycle as rx_valid. The RX FIFO must therefore have ≥1 word of slack.
- Sustained throughput is 1 word/cycle when tx_ready=1 and the FIFO is non-empty.

## Test plan
- Single channel: ch0 cnt=3 holding words 1,2,3; tx_ready=1 → tx stream A5000003,1,2,3; tx_fifo_rd_o[0] pulses 3 times; FSM returns to T_IDLE.
- Round-robin: NCH=4, ch1 and ch3 both with cnt=2 → packets emitted in the order ch1, ch3, ch1, ...; no channel is sent twice in a row while another channel is pending.
- Burst cap: ch0 cnt=100, MAX_BURST=64 → header A5000040 with 64 data words, then header A5000024 with 36 data words.
- Backpressure: tx_ready toggled 1,0,1,0 during T_DATA → tx_data is held stable while tx_ready=0; pops occur only on cycles with tx_ready=1; no word is lost or duplicated.
- RX demux and drop: inject A5010002,AA,BB with rx_fifo_full_i[1]=1 on BB → FIFO1 receives AA one cycle after it arrives; rx_drop_cnt=1.
- Errors: inject header 12000004 → hdr_err_cnt=1 and the FSM stays in R_HDR. Drop channel_up after 2 of 5 TX words → tx_abort_cnt=1; the next packet restarts with a fresh header once channel_up=1 again.
